uart_tx_fifo: RTL and testbench

//   Buffered, parametrised UART transmitter for the mother_board I/O path.
//   The CPU io-write pushes characters into a DEPTH-entry FIFO; a frame engine

---
 rtl/uart_tx_fifo.sv | 155 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a small FIFO feeds a start/data/parity/stop frame
// engine that drains queued characters back-to-back onto a registered line.
module uart_tx_fifo #(
  parameter int WAIT      = 868,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_en,
  input  logic [DATA_BITS-1:0]   wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   busy,
  output logic                   uart_tx
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int TW = $clog2(WAIT);
  localparam int IW = $clog2(DATA_BITS);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t                 state_reg, state_next;
  logic [TW-1:0]          timer_reg, timer_next;
  logic [IW-1:0]          idx_reg, idx_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_reg, par_next;
  logic                   tx_reg, tx_next;
  logic [LW-1:0]          level_reg;
  logic [AW-1:0]          wr_ptr_reg, rd_ptr_reg;
  logic                   ovf_reg;
  logic                   push, pop, bit_end;
  logic [DATA_BITS-1:0]   head;

  logic [DATA_BITS-1:0]   mem [DEPTH];

  // Full is judged on the current level, so a push that coincides with a pop
  // while full is still dropped.
  assign full    = (level_reg == LW'(DEPTH));
  assign push    = wr_en && !full;
  assign head    = mem[rd_ptr_reg];
  assign bit_end = (timer_reg == TW'(WAIT - 1));

  assign level    = level_reg;
  assign overflow = ovf_reg;
  assign busy     = (state_reg != IDLE) || (level_reg != '0);
  assign uart_tx  = tx_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_comb begin
    state_next = state_reg;
    timer_next = bit_end ? '0 : timer_reg + TW'(1);
    idx_next   = idx_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        timer_next = '0;
        if (level_reg != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          idx_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_reg == IW'(DATA_BITS - 1)) begin
            state_next = (PARITY != 0) ? PAR : STOP;
            idx_next   = '0;
          end else begin
            idx_next   = idx_reg + IW'(1);
            shift_next = shift_reg >> 1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          state_next = STOP;
          idx_next   = '0;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (idx_reg == IW'(STOP_BITS - 1)) begin
            idx_next = '0;
            if (level_reg != '0) begin
              pop        = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            idx_next = idx_reg + IW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (pop) begin
      shift_next = head;
      par_next   = (PARITY == 1) ? ~^head : ^head;
      idx_next   = '0;
    end

    // Line level is derived from the next state so the output stays registered.
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PAR:     tx_next = par_next;
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= IDLE;
      timer_reg  <= '0;
      idx_reg    <= '0;
      shift_reg  <= '0;
      par_reg    <= 1'b0;
      tx_reg     <= 1'b1;
      level_reg  <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      idx_reg    <= idx_next;
      shift_reg  <= shift_next;
      par_reg    <= par_next;
      tx_reg     <= tx_next;
      level_reg  <= level_reg + LW'(push) - LW'(pop);
      ovf_reg    <= wr_en && full;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four transmitter variants (8N1, 8E1, 8O1, 7N2) at WAIT=4,
// line and busy logged every cycle and compared against hand-built frames.
module tb_uart_tx_fifo;

  localparam int W    = 4;
  localparam int LOGN = 8192;

  logic            clk;
  logic            reset;
  logic [3:0]      wr_en;
  logic [7:0]      wr_d0, wr_d1, wr_d2;
  logic [6:0]      wr_d3;
  logic [3:0]      tx_w, busy_w, full_w, ovf_w;
  logic [3:0][2:0] lvl_w;

  logic [3:0] tx_log   [LOGN];
  logic [3:0] busy_log [LOGN];
  int cyc = 0;
  int err_cnt = 0;
  int chk_cnt = 0;

  uart_tx_fifo #(.WAIT(W), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut_8n1 (
    .clk(clk), .reset(reset), .wr_en(wr_en[0]), .wr_data(wr_d0), .full(full_w[0]),
    .level(lvl_w[0]), .overflow(ovf_w[0]), .busy(busy_w[0]), .uart_tx(tx_w[0]));
  uart_tx_fifo #(.WAIT(W), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DEPTH(4)) dut_8e1 (
    .clk(clk), .reset(reset), .wr_en(wr_en[1]), .wr_data(wr_d1), .full(full_w[1]),
    .level(lvl_w[1]), .overflow(ovf_w[1]), .busy(busy_w[1]), .uart_tx(tx_w[1]));
  uart_tx_fifo #(.WAIT(W), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) dut_8o1 (
    .clk(clk), .reset(reset), .wr_en(wr_en[2]), .wr_data(wr_d2), .full(full_w[2]),
    .level(lvl_w[2]), .overflow(ovf_w[2]), .busy(busy_w[2]), .uart_tx(tx_w[2]));
  uart_tx_fifo #(.WAIT(W), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DEPTH(4)) dut_7n2 (
    .clk(clk), .reset(reset), .wr_en(wr_en[3]), .wr_data(wr_d3), .full(full_w[3]),
    .level(lvl_w[3]), .overflow(ovf_w[3]), .busy(busy_w[3]), .uart_tx(tx_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The sample taken on the negedge after rising edge n lands at index n.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc < LOGN) begin
        tx_log[cyc]   = tx_w;
        busy_log[cyc] = busy_w;
      end
      cyc++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // bits[i] is the i-th line level of the frame in time order, starting at log index s.
  task automatic check_frame(input string tag, input int sel, input int s,
                             input logic [15:0] bits, input int nbits);
    int  g;
    logic ok, v;
    g = 0;
    while (cyc <= s + nbits * W && g < 5000) begin
      step();
      g++;
    end
    if (g >= 5000) check({tag, "_timeout"}, 32'd0, 32'd1);
    for (int b = 0; b < nbits; b++) begin
      ok = 1'b1;
      for (int c = 0; c < W; c++)
        if (tx_log[s + b * W + c][sel] !== bits[b]) ok = 1'b0;
      v = ok ? bits[b] : ~bits[b];
      check($sformatf("%s_bit%0d", tag, b), 32'(v), 32'(bits[b]));
    end
    check({tag, "_busy"}, 32'(busy_log[s][sel]), 32'd1);
    $display("frame %s: %0d bits from cycle %0d checked", tag, nbits, s);
  endtask

  logic [7:0] bb [5];
  int s, s0;
  logic quiet;

  initial begin
    bb = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h3C};
    wr_en = '0;
    wr_d0 = '0; wr_d1 = '0; wr_d2 = '0; wr_d3 = '0;
    reset = 1'b0;
    repeat (2) step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_tx%0d", i),    32'(tx_w[i]),   32'd1);
      check($sformatf("rst_busy%0d", i),  32'(busy_w[i]), 32'd0);
      check($sformatf("rst_full%0d", i),  32'(full_w[i]), 32'd0);
      check($sformatf("rst_ovf%0d", i),   32'(ovf_w[i]),  32'd0);
      check($sformatf("rst_level%0d", i), 32'(lvl_w[i]),  32'd0);
    end
    reset = 1'b1;
    step();

    // 8N1 single frame of 0x5A
    wr_d0 = 8'h5A; wr_en[0] = 1'b1;
    step();
    wr_en[0] = 1'b0;
    s = cyc + 1;
    check("t2_level", 32'(lvl_w[0]), 32'd1);
    check("t2_busy_push", 32'(busy_w[0]), 32'd1);
    check_frame("t2", 0, s, {1'b1, 8'h5A, 1'b0}, 10);
    check("t2_idle_tx", 32'(tx_log[s + 40][0]), 32'd1);
    check("t2_idle_busy", 32'(busy_log[s + 40][0]), 32'd0);
    check("t2_last_busy", 32'(busy_log[s + 39][0]), 32'd1);

    // Even / odd parity and 7N2 in parallel
    wr_d1 = 8'h5A; wr_d2 = 8'h5A; wr_d3 = 7'h41;
    wr_en[3:1] = 3'b111;
    step();
    wr_en[3:1] = 3'b000;
    s = cyc + 1;
    check_frame("t3_even", 1, s, {1'b1, 1'b0, 8'h5A, 1'b0}, 11);
    check_frame("t3_odd",  2, s, {1'b1, 1'b1, 8'h5A, 1'b0}, 11);
    check_frame("t5_7n2",  3, s, {2'b11, 7'h41, 1'b0}, 10);
    check("t3_even_idle", 32'(busy_log[s + 44][1]), 32'd0);
    check("t3_odd_idle",  32'(busy_log[s + 44][2]), 32'd0);
    check("t3_even_busy_end", 32'(busy_log[s + 43][1]), 32'd1);
    check("t5_idle_busy", 32'(busy_log[s + 40][3]), 32'd0);
    check("t5_idle_tx",   32'(tx_log[s + 40][3]), 32'd1);

    // Burst of six pushes: five accepted, the sixth overflows
    step();
    wr_en[0] = 1'b1;
    wr_d0 = bb[0]; step();
    s = cyc + 1;
    wr_d0 = bb[1]; step();
    check("t4_level_pushpop", 32'(lvl_w[0]), 32'd1);
    wr_d0 = bb[2]; step();
    wr_d0 = bb[3]; step();
    wr_d0 = bb[4]; step();
    check("t4_level4", 32'(lvl_w[0]), 32'd4);
    check("t4_full",   32'(full_w[0]), 32'd1);
    check("t4_no_ovf", 32'(ovf_w[0]), 32'd0);
    wr_d0 = 8'hEE; step();
    wr_en[0] = 1'b0;
    check("t4_ovf_pulse", 32'(ovf_w[0]), 32'd1);
    check("t4_level_kept", 32'(lvl_w[0]), 32'd4);
    step();
    check("t4_ovf_clear", 32'(ovf_w[0]), 32'd0);
    for (int n = 0; n < 5; n++)
      check_frame($sformatf("t4_f%0d", n), 0, s + 40 * n, {1'b1, bb[n], 1'b0}, 10);
    while (cyc <= s + 201) step();
    check("t4_idle_tx",   32'(tx_log[s + 200][0]), 32'd1);
    check("t4_idle_busy", 32'(busy_log[s + 200][0]), 32'd0);

    // Reset during data bit 3 with two characters queued
    step();
    wr_en[0] = 1'b1;
    wr_d0 = 8'h11; step();
    wr_d0 = 8'h22; step();
    wr_d0 = 8'h33; step();
    wr_en[0] = 1'b0;
    repeat (16) step();
    check("t6_level_before", 32'(lvl_w[0]), 32'd2);
    check("t6_bit3_before", 32'(tx_w[0]), 32'd0);
    check("t6_busy_before", 32'(busy_w[0]), 32'd1);
    reset = 1'b0;
    #1;
    check("t1_tx_async",    32'(tx_w[0]),   32'd1);
    check("t1_busy_async",  32'(busy_w[0]), 32'd0);
    check("t1_full_async",  32'(full_w[0]), 32'd0);
    check("t1_level_async", 32'(lvl_w[0]),  32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t1_hold_tx%0d", i),    32'(tx_w[0]),   32'd1);
      check($sformatf("t1_hold_level%0d", i), 32'(lvl_w[0]),  32'd0);
      check($sformatf("t1_hold_busy%0d", i),  32'(busy_w[0]), 32'd0);
    end
    reset = 1'b1;
    s0 = cyc;
    repeat (10) step();
    quiet = 1'b1;
    for (int i = s0 + 1; i < s0 + 10; i++)
      if (tx_log[i][0] !== 1'b1 || busy_log[i][0] !== 1'b0) quiet = 1'b0;
    check("t1_no_stray", 32'(quiet), 32'd1);
    wr_d0 = 8'hA5; wr_en[0] = 1'b1;
    step();
    wr_en[0] = 1'b0;
    s = cyc + 1;
    check_frame("t6_A5", 0, s, {1'b1, 8'hA5, 1'b0}, 10);
    while (cyc <= s + 41) step();
    check("t6_idle_tx",   32'(tx_log[s + 40][0]), 32'd1);
    check("t6_idle_busy", 32'(busy_log[s + 40][0]), 32'd0);
    check("t6_level_end", 32'(lvl_w[0]), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
